// File: rtl/sapho_io_pkg.sv
// Shared definitions for the SAPHO processor IO-side FIFOs.
// FIFO state encoding plus width helpers used by output and input FIFOs.
package sapho_io_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } fifo_st_e;

    localparam int IO_NUBITS = 16;
    localparam int IO_NUIOOU = 8;
    localparam int IO_FDEPTH = 16;

    // Address width that stays at least one bit for a single-address bus.
    function automatic int io_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_fifo_mem.sv
// FIFO storage array: one synchronous write port, asynchronous head read.
// Contents are not reset; validity is tracked by the owning FIFO.
module io_fifo_mem #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/io_out_fifo.sv
// Output-side IO FIFO: captures proc_fx output writes, drains via valid/ready.
// Define IO_FIFO_TAG_EN to store the output address with each entry (m_tag).
module io_out_fifo
    import sapho_io_pkg::*;
#(
    parameter int NUBITS = IO_NUBITS,
    parameter int NUIOOU = IO_NUIOOU,
    parameter int FDEPTH = IO_FDEPTH,
    parameter logic [NUIOOU-1:0] ENMASK = {NUIOOU{1'b1}},
    localparam int FAW = $clog2(FDEPTH),
    localparam int AW  = io_aw(NUIOOU)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              out_en,
    input  logic [AW-1:0]     addr_out,
    input  logic [NUBITS-1:0] io_out,
    output logic [NUBITS-1:0] m_data,
`ifdef IO_FIFO_TAG_EN
    output logic [AW-1:0]     m_tag,
`endif
    output logic              m_valid,
    input  logic              m_ready,
    output logic [FAW:0]      count,
    output logic              ovf,
    input  logic              ovf_clr
);

`ifdef IO_FIFO_TAG_EN
    localparam int W = NUBITS + AW;
`else
    localparam int W = NUBITS;
`endif

    localparam logic [FAW:0] CNT_ONE  = (FAW+1)'(1);
    localparam logic [FAW:0] CNT_LAST = (FAW+1)'(FDEPTH - 1);

    fifo_st_e       state;
    fifo_st_e       state_n;
    logic [FAW:0]   count_n;
    logic [FAW-1:0] wr_ptr;
    logic [FAW-1:0] rd_ptr;
    logic           push;
    logic           pop;
    logic           wr_en;
    logic           drop;
    logic [W-1:0]   wdata;
    logic [W-1:0]   head;

    assign push    = out_en & ENMASK[addr_out];
    assign m_valid = (state != ST_EMPTY);
    assign pop     = m_valid & m_ready;

`ifdef IO_FIFO_TAG_EN
    assign wdata = {addr_out, io_out};
    assign m_tag = m_valid ? head[W-1:NUBITS] : '0;
`else
    assign wdata = io_out;
`endif
    assign m_data = m_valid ? head[NUBITS-1:0] : '0;

    always_comb begin
        state_n = state;
        count_n = count;
        wr_en   = 1'b0;
        drop    = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (push) begin
                    wr_en   = 1'b1;
                    count_n = CNT_ONE;
                    state_n = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (push && !pop) begin
                    wr_en   = 1'b1;
                    count_n = count + CNT_ONE;
                    state_n = (count == CNT_LAST) ? ST_FULL : ST_ACTIVE;
                end else if (pop && !push) begin
                    count_n = count - CNT_ONE;
                    state_n = (count == CNT_ONE) ? ST_EMPTY : ST_ACTIVE;
                end else if (push && pop) begin
                    wr_en = 1'b1;
                end
            end
            ST_FULL: begin
                if (push && !pop) begin
                    drop = 1'b1;
                end else if (pop && !push) begin
                    count_n = count - CNT_ONE;
                    state_n = ST_ACTIVE;
                end else if (push && pop) begin
                    // Head slot is freed on the same edge it is refilled.
                    wr_en = 1'b1;
                end
            end
            default: begin
                state_n = ST_EMPTY;
                count_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    io_fifo_mem #(
        .W     (W),
        .DEPTH (FDEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en & ~rst),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (head)
    );

endmodule

// File: tb/tb_io_out_fifo.sv
// Self-checking bench for io_out_fifo: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_io_out_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_en;
    logic [2:0]  addr_out;
    logic [15:0] io_out;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  count;
    logic        ovf;
    logic        ovf_clr;

    logic        out_en2;
    logic [2:0]  addr_out2;
    logic [15:0] io_out2;
    logic [15:0] m_data2;
    logic        m_valid2;
    logic        m_ready2;
    logic [4:0]  count2;
    logic        ovf2;
    logic        ovf_clr2;

`ifdef IO_FIFO_TAG_EN
    logic [2:0]  m_tag;
    logic [2:0]  m_tag2;
`endif

    int tests = 0;
    int fails = 0;

    logic [18:0] mq[$];
    logic        movf;

    always #5 clk = ~clk;

    io_out_fifo u_dut (
        .clk      (clk),
        .rst      (rst),
        .out_en   (out_en),
        .addr_out (addr_out),
        .io_out   (io_out),
        .m_data   (m_data),
`ifdef IO_FIFO_TAG_EN
        .m_tag    (m_tag),
`endif
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .count    (count),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    io_out_fifo #(.ENMASK(8'b0000_0001)) u_msk (
        .clk      (clk),
        .rst      (rst),
        .out_en   (out_en2),
        .addr_out (addr_out2),
        .io_out   (io_out2),
        .m_data   (m_data2),
`ifdef IO_FIFO_TAG_EN
        .m_tag    (m_tag2),
`endif
        .m_valid  (m_valid2),
        .m_ready  (m_ready2),
        .count    (count2),
        .ovf      (ovf2),
        .ovf_clr  (ovf_clr2)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, int'(count), n);
        chk({tag, ".valid"}, int'(m_valid), (n > 0) ? 1 : 0);
        chk({tag, ".data"}, int'(m_data), (n > 0) ? int'(mq[0][15:0]) : 0);
        chk({tag, ".ovf"}, int'(ovf), int'(movf));
`ifdef IO_FIFO_TAG_EN
        chk({tag, ".tag"}, int'(m_tag), (n > 0) ? int'(mq[0][18:16]) : 0);
`endif
    endtask

    // One clock of stimulus on the main DUT; the model follows the rules
    // for a 16-entry lossless-unless-full queue with sticky overflow.
    task automatic cyc(input logic oe, input logic [2:0] a,
                       input logic [15:0] d, input logic rdy,
                       input logic clr, input string tag);
        bit dropped;
        out_en   = oe;
        addr_out = a;
        io_out   = d;
        m_ready  = rdy;
        ovf_clr  = clr;
        if (rst) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            dropped = 1'b0;
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (oe) begin
                if (mq.size() == 16) dropped = 1'b1;
                else mq.push_back({a, d});
            end
            if (dropped) movf = 1'b1;
            else if (clr) movf = 1'b0;
        end
        tick();
        cmp_model(tag);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, "rst");
        rst = 1'b0;
    endtask

    task automatic fill16(input int base);
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 3'(i), 16'(base + i), 1'b0, 1'b0, "fill");
    endtask

    typedef struct {
        logic        oe;
        logic [2:0]  a;
        logic [15:0] d;
        logic        rdy;
        logic        clr;
        int          cnt;
        logic        vld;
        logic [15:0] q;
        logic [2:0]  tg;
        logic        ov;
    } vec_t;

    vec_t vt[8];

    initial begin
        rst = 1'b1;
        out_en = 0; addr_out = 0; io_out = 0; m_ready = 0; ovf_clr = 0;
        out_en2 = 0; addr_out2 = 0; io_out2 = 0; m_ready2 = 0; ovf_clr2 = 0;
        movf = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("reset.count", int'(count), 0);
        chk("reset.valid", int'(m_valid), 0);
        chk("reset.data", int'(m_data), 0);
        chk("reset.ovf", int'(ovf), 0);
        chk("reset.msk_count", int'(count2), 0);

        vt[0] = '{1, 3'd2, 16'h1234, 0, 0, 1, 1, 16'h1234, 3'd2, 0};
        vt[1] = '{1, 3'd1, 16'h5555, 0, 0, 2, 1, 16'h1234, 3'd2, 0};
        vt[2] = '{0, 3'd0, 16'h0000, 0, 0, 2, 1, 16'h1234, 3'd2, 0};
        vt[3] = '{1, 3'd0, 16'h0042, 1, 0, 2, 1, 16'h5555, 3'd1, 0};
        vt[4] = '{0, 3'd0, 16'h0000, 1, 0, 1, 1, 16'h0042, 3'd0, 0};
        vt[5] = '{0, 3'd0, 16'h0000, 1, 0, 0, 0, 16'h0000, 3'd0, 0};
        vt[6] = '{0, 3'd0, 16'h0000, 1, 0, 0, 0, 16'h0000, 3'd0, 0};
        vt[7] = '{0, 3'd0, 16'h0000, 0, 1, 0, 0, 16'h0000, 3'd0, 0};
        for (int i = 0; i < 8; i++) begin
            cyc(vt[i].oe, vt[i].a, vt[i].d, vt[i].rdy, vt[i].clr, "vec");
            chk($sformatf("vec%0d.count", i), int'(count), vt[i].cnt);
            chk($sformatf("vec%0d.valid", i), int'(m_valid), int'(vt[i].vld));
            chk($sformatf("vec%0d.data", i), int'(m_data), int'(vt[i].q));
            chk($sformatf("vec%0d.ovf", i), int'(ovf), int'(vt[i].ov));
`ifdef IO_FIFO_TAG_EN
            chk($sformatf("vec%0d.tag", i), int'(m_tag), int'(vt[i].tg));
`endif
        end

        // Fill to full, drop the 17th, drain in order.
        do_reset();
        fill16(0);
        chk("full.count", int'(count), 16);
        cyc(1'b1, 3'd5, 16'd777, 1'b0, 1'b0, "drop");
        chk("drop.ovf", int'(ovf), 1);
        chk("drop.count", int'(count), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), int'(m_data), i);
            cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, "drain");
        end
        chk("drained.valid", int'(m_valid), 0);

        // Push and pop together while full.
        do_reset();
        fill16(100);
        cyc(1'b1, 3'd7, 16'd99, 1'b1, 1'b0, "pushpop");
        chk("pushpop.count", int'(count), 16);
        chk("pushpop.ovf", int'(ovf), 0);
        chk("pushpop.head", int'(m_data), 101);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("pushpop.last", int'(m_data), 99);
            cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, "ppdrain");
        end

        // Overflow clear races a drop, then stands alone.
        do_reset();
        fill16(200);
        cyc(1'b1, 3'd0, 16'd1, 1'b0, 1'b1, "clrdrop");
        chk("clrdrop.ovf", int'(ovf), 1);
        cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b1, "clr");
        chk("clr.ovf", int'(ovf), 0);

        // Masked instance: only address 0 is captured.
        out_en2 = 1'b1; addr_out2 = 3'd3; io_out2 = 16'hBEEF;
        tick();
        out_en2 = 1'b0;
        chk("mask.addr3_count", int'(count2), 0);
        chk("mask.addr3_ovf", int'(ovf2), 0);
        out_en2 = 1'b1; addr_out2 = 3'd0; io_out2 = 16'h0007;
        tick();
        out_en2 = 1'b0;
        chk("mask.addr0_count", int'(count2), 1);
        chk("mask.addr0_data", int'(m_data2), 7);
        chk("mask.addr0_valid", int'(m_valid2), 1);

        // Random traffic with a reset in the middle.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                rst = 1'b1;
                cyc(1'b1, 3'd1, 16'hAAAA, 1'b1, 1'b0, "midrst");
                rst = 1'b0;
                chk("midrst.count", int'(count), 0);
                chk("midrst.valid", int'(m_valid), 0);
            end else begin
                cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    16'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 19) == 0), "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
